// File: rtl/tile_pixel_fetch.sv
// tile_pixel_fetch: fetches one glyph row from tile memory per character
// request and serialises it as eight fg/bg colour indices, MSB first.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; valid may not depend on ready, and a source
// holding valid high keeps its payload stable until the transfer.
module tile_pixel_fetch #(
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  input  logic [7:0]        char_code_i,
  input  logic [7:0]        char_attr_i,
  input  logic [3:0]        row_i,
  input  logic [AWIDTH-1:0] font_base_i,
  input  logic              font_h16_i,
  output logic              tile_rd_en_o,
  output logic [AWIDTH-1:0] tile_addr_o,
  input  logic [15:0]       tile_data_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [3:0]        pix_color_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic              consume;
  logic              load;
  logic [AWIDTH-1:0] addr_d;
  logic              byte_sel_q;
  logic [7:0]        attr_q;
  logic [7:0]        hold_q;
  logic [7:0]        pattern_q;
  logic [7:0]        shift_attr_q;
  logic [3:0]        count_q;

  assign char_ready_o = (state_q == IDLE);
  assign accept       = char_ready_o & char_valid_i;
  assign consume      = pix_valid_o & pix_ready_i;
  // The shifter can take the held byte when empty, or when its last pixel
  // leaves this cycle; the latter keeps back-to-back output gapless.
  assign load         = (state_q == HOLD) &&
                        ((count_q == 4'd0) || ((count_q == 4'd1) && consume));
  assign pix_valid_o  = (count_q != 4'd0);
  assign pix_color_o  = pattern_q[7] ? shift_attr_q[3:0] : shift_attr_q[7:4];
  assign dbg_state_o  = state_q;

  // Glyph row word address; 8x16 glyphs occupy 8 words, 8x8 glyphs 4 words,
  // each word carrying two rows. The sum wraps at the address width.
  always_comb begin
    addr_d = '0;
    if (font_h16_i) begin
      addr_d = font_base_i + AWIDTH'({char_code_i, 3'b000}) + AWIDTH'(row_i[3:1]);
    end else begin
      addr_d = font_base_i + AWIDTH'({char_code_i, 2'b00}) + AWIDTH'(row_i[2:1]);
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state: one read cycle, one capture cycle, then wait in
  // HOLD until the shifter can take the byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (char_valid_i) state_d = READ;
      READ:    state_d = CAPT;
      CAPT:    state_d = HOLD;
      HOLD:    if (load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch: address, attribute and byte select are taken only at
  // accept, so later input changes cannot disturb the fetch in flight.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      tile_rd_en_o <= 1'b0;
      tile_addr_o  <= '0;
      attr_q       <= '0;
      byte_sel_q   <= 1'b0;
    end else begin
      tile_rd_en_o <= accept;
      if (accept) begin
        tile_addr_o <= addr_d;
        attr_q      <= char_attr_i;
        byte_sel_q  <= row_i[0];
      end
    end
  end

  // Capture the addressed row byte; even rows live in the high byte.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      hold_q <= '0;
    end else if (state_q == CAPT) begin
      hold_q <= byte_sel_q ? tile_data_i[7:0] : tile_data_i[15:8];
    end
  end

  // Pixel shifter: load wins over shift; attribute travels with the pattern
  // so the next request may overwrite attr_q while pixels still stream out.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pattern_q    <= '0;
      shift_attr_q <= '0;
      count_q      <= '0;
    end else if (load) begin
      pattern_q    <= hold_q;
      shift_attr_q <= attr_q;
      count_q      <= 4'd8;
    end else if (consume) begin
      pattern_q    <= {pattern_q[6:0], 1'b0};
      count_q      <= count_q - 4'd1;
    end
  end

endmodule
